layer_compositor: RTL and testbench

//  Parametrised N-layer pixel compositor for the 1280x1024 VGA pipeline. Per-pixel fixed-priority

---
 rtl/layer_compositor_if.sv | 55 +++++
 rtl/layer_compositor.sv | 166 ++++++++++++++++
 tb/tb_layer_compositor.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/layer_compositor_if.sv
`default_nettype none
// ============================================================================
// Module      : layer_compositor_if
// Description : Pixel-side bundle for the layer compositor. Carries the
//               timing position, per-layer pixel data, collision masks and
//               the registered colour / collision / scroll results.
//               The master modport is the pixel source (generators and
//               vga_controller). The slave modport is the compositor.
// Revision    : 1.0 - initial release
// ============================================================================
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 6,
    parameter int COLOR_W    = 4,
    parameter int COL_W      = 12,
    parameter int ROW_W      = 11
);
    // Pixel position and per-layer inputs
    logic                              visible;
    logic [COL_W-1:0]                  display_col;
    logic [ROW_W-1:0]                  display_row;
    logic [NUM_LAYERS-1:0]             layer_visible;
    logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb;
    logic [3*COLOR_W-1:0]              bg_rgb;
    logic [NUM_LAYERS-1:0]             player_mask;
    logic [NUM_LAYERS-1:0]             hazard_mask;
    logic                              hit_clear;

    // Registered results
    logic [COLOR_W-1:0]                red;
    logic [COLOR_W-1:0]                green;
    logic [COLOR_W-1:0]                blue;
    logic                              hit;
    logic                              hit_pulse;
    logic [COL_W-1:0]                  hit_col;
    logic [ROW_W-1:0]                  hit_row;
    logic [NUM_LAYERS-1:0]             hit_layers;
    logic [COL_W-1:0]                  scroll_offset;

    // Pixel source side
    modport master (
        output visible, display_col, display_row, layer_visible, layer_rgb,
               bg_rgb, player_mask, hazard_mask, hit_clear,
        input  red, green, blue, hit, hit_pulse, hit_col, hit_row,
               hit_layers, scroll_offset
    );

    // Compositor side
    modport slave (
        input  visible, display_col, display_row, layer_visible, layer_rgb,
               bg_rgb, player_mask, hazard_mask, hit_clear,
        output red, green, blue, hit, hit_pulse, hit_col, hit_row,
               hit_layers, scroll_offset
    );
endinterface
`default_nettype wire

// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
// Module      : layer_compositor
// Description : N-layer pixel compositor. Fixed-priority colour mux (layer 0
//               highest) with background fallback, sticky player/hazard
//               collision detection with first-hit coordinate capture, and a
//               per-frame scroll offset that freezes while a hit is latched.
//               Optional macro LAYER_COMPOSITOR_HIT_LAYERS_EN builds sticky
//               per-layer hazard-hit flags; without it hit_layers is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_compositor #(
    parameter int NUM_LAYERS  = 6,
    parameter int COLOR_W     = 4,
    parameter int COL_W       = 12,
    parameter int ROW_W       = 11,
    parameter int SCROLL_STEP = 3
) (
    input  wire logic          clock,
    input  wire logic          reset,
    layer_compositor_if.slave  bus
);

    localparam int                    PIX_W     = 3 * COLOR_W;
    localparam logic [NUM_LAYERS-1:0] LAYER_ONE = NUM_LAYERS'(1);
    localparam logic [COL_W-1:0]      STEP      = COL_W'(SCROLL_STEP);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [PIX_W-1:0]      pix_q,    pix_d;
    logic                  hit_q,    hit_d;
    logic                  pulse_q,  pulse_d;
    logic [COL_W-1:0]      hcol_q,   hcol_d;
    logic [ROW_W-1:0]      hrow_q,   hrow_d;
    logic [COL_W-1:0]      scroll_q, scroll_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NUM_LAYERS-1:0] player_vis;
    logic [NUM_LAYERS-1:0] hazard_vis;
    logic                  player_single;
    logic                  self_only;
    logic                  collision;
    logic                  frame_start;

    assign player_vis    = bus.layer_visible & bus.player_mask;
    assign hazard_vis    = bus.layer_visible & bus.hazard_mask;
    assign player_single = ((player_vis & (player_vis - LAYER_ONE)) == '0);

    // The only way both sets are non-empty yet no distinct player/hazard
    // pair exists is a single visible layer that sits in both masks.
    assign self_only     = player_single && (player_vis == hazard_vis);
    assign collision     = bus.visible && (|player_vis) && (|hazard_vis) && !self_only;

    // Frame boundary is positional only; blanking does not matter here.
    assign frame_start   = (bus.display_col == '0) && (bus.display_row == '0);

    // Fixed-priority colour select: scan from the lowest priority upward so
    // the lowest visible index is the last one written.
    always_comb begin
        pix_d = '0;
        if (bus.visible) begin
            pix_d = bus.bg_rgb;
            for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
                if (bus.layer_visible[i]) begin
                    pix_d = bus.layer_rgb[i*PIX_W +: PIX_W];
                end
            end
        end
    end

    // Sticky hit flag, first-hit coordinates and the rising-edge pulse.
    // A collision in the same cycle as a clear restarts the hit, so the
    // coordinates are recaptured and the pulse fires again.
    always_comb begin
        hit_d   = hit_q;
        pulse_d = 1'b0;
        hcol_d  = hcol_q;
        hrow_d  = hrow_q;
        if (collision) begin
            hit_d = 1'b1;
            if (!hit_q || bus.hit_clear) begin
                pulse_d = 1'b1;
                hcol_d  = bus.display_col;
                hrow_d  = bus.display_row;
            end
        end else if (bus.hit_clear) begin
            hit_d  = 1'b0;
            hcol_d = '0;
            hrow_d = '0;
        end
    end

    // Scroll advances once per frame unless a hit is currently latched.
    always_comb begin
        scroll_d = scroll_q;
        if (frame_start && !hit_q) begin
            scroll_d = scroll_q + STEP;
        end
    end

    // Main state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_q    <= '0;
            hit_q    <= 1'b0;
            pulse_q  <= 1'b0;
            hcol_q   <= '0;
            hrow_q   <= '0;
            scroll_q <= '0;
        end else begin
            pix_q    <= pix_d;
            hit_q    <= hit_d;
            pulse_q  <= pulse_d;
            hcol_q   <= hcol_d;
            hrow_q   <= hrow_d;
            scroll_q <= scroll_d;
        end
    end

`ifdef LAYER_COMPOSITOR_HIT_LAYERS_EN
    // ------------------------------------------------------------------
    // Per-layer hazard-hit flags. Layers that are also player layers are
    // excluded so a player never reports itself as a hazard.
    // ------------------------------------------------------------------
    logic [NUM_LAYERS-1:0] hlay_q, hlay_d;

    // Clear first, then merge this pixel's hazards so a same-cycle
    // collision survives the clear.
    always_comb begin
        hlay_d = bus.hit_clear ? '0 : hlay_q;
        if (collision) begin
            hlay_d = hlay_d | (bus.layer_visible & bus.hazard_mask & ~bus.player_mask);
        end
    end

    // Per-layer flag register.
    always_ff @(posedge clock) begin
        if (reset) begin
            hlay_q <= '0;
        end else begin
            hlay_q <= hlay_d;
        end
    end

    assign bus.hit_layers = hlay_q;
`else
    assign bus.hit_layers = '0;
`endif

    // ------------------------------------------------------------------
    // Output mapping: colour words are packed {R,G,B}.
    // ------------------------------------------------------------------
    assign bus.red           = pix_q[PIX_W-1     -: COLOR_W];
    assign bus.green         = pix_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue          = pix_q[COLOR_W-1   -: COLOR_W];
    assign bus.hit           = hit_q;
    assign bus.hit_pulse     = pulse_q;
    assign bus.hit_col       = hcol_q;
    assign bus.hit_row       = hrow_q;
    assign bus.scroll_offset = scroll_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_compositor
// Description : Scoreboard bench for layer_compositor. The stimulus task
//               drives one pixel per cycle and pushes the model's expected
//               post-edge outputs; an independent monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_compositor;

    localparam int NL = 6;

    typedef struct {
        logic [3:0]  r, g, b;
        logic        hit, pulse;
        logic [11:0] col;
        logic [10:0] row;
        logic [5:0]  hl;
        logic [11:0] scroll;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // reference model state
    logic        m_hit;
    logic [11:0] m_col;
    logic [10:0] m_row;
    logic [5:0]  m_hl;
    logic [11:0] m_scroll;

    layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(4), .COL_W(12), .ROW_W(11)) bus ();

    layer_compositor #(
        .NUM_LAYERS (NL),
        .COLOR_W    (4),
        .COL_W      (12),
        .ROW_W      (11),
        .SCROLL_STEP(3)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Drive one pixel and push what the outputs must be after the next edge.
    task automatic apply(input logic r, input logic v, input logic [11:0] c,
                         input logic [10:0] rw, input logic [5:0] lv,
                         input logic [71:0] rgb, input logic [11:0] bg,
                         input logic [5:0] pm, input logic [5:0] hm, input logic clr);
        exp_t        e;
        logic [11:0] px;
        logic        coll;
        logic        found;
        @(negedge clk);
        rst               = r;
        bus.visible       = v;
        bus.display_col   = c;
        bus.display_row   = rw;
        bus.layer_visible = lv;
        bus.layer_rgb     = rgb;
        bus.bg_rgb        = bg;
        bus.player_mask   = pm;
        bus.hazard_mask   = hm;
        bus.hit_clear     = clr;
        e.pulse = 1'b0;
        if (r) begin
            m_hit = 0; m_col = 0; m_row = 0; m_hl = 0; m_scroll = 0;
            px = 12'h000;
        end else begin
            // colour: first visible layer in index order, else background
            px    = 12'h000;
            found = 1'b0;
            if (v) begin
                px = bg;
                for (int i = 0; i < NL; i++) begin
                    if (!found && lv[i]) begin
                        px    = rgb[i*12 +: 12];
                        found = 1'b1;
                    end
                end
            end
            // collision: some visible player layer and a different visible hazard layer
            coll = 1'b0;
            for (int p = 0; p < NL; p++)
                for (int h = 0; h < NL; h++)
                    if (v && p != h && lv[p] && pm[p] && lv[h] && hm[h]) coll = 1'b1;
            if (c == 0 && rw == 0 && !m_hit) m_scroll = m_scroll + 12'd3;
            if (clr) m_hl = 6'b0;
            if (coll) begin
                if (!m_hit || clr) begin
                    m_col   = c;
                    m_row   = rw;
                    e.pulse = 1'b1;
                end
                m_hit = 1'b1;
                m_hl  = m_hl | (lv & hm & ~pm);
            end else if (clr) begin
                m_hit = 0; m_col = 0; m_row = 0;
            end
        end
        e.r = px[11:8]; e.g = px[7:4]; e.b = px[3:0];
        e.hit = m_hit; e.col = m_col; e.row = m_row; e.scroll = m_scroll;
`ifdef LAYER_COMPOSITOR_HIT_LAYERS_EN
        e.hl = m_hl;
`else
        e.hl = 6'b0;
`endif
        sb_q.push_back(e);
    endtask

    task automatic rand_apply(input logic r);
        logic [95:0] w;
        logic [11:0] c;
        logic [10:0] rw;
        w  = {$urandom, $urandom, $urandom};
        c  = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(0, 1279));
        rw = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom_range(0, 1023));
        apply(r, ($urandom_range(0, 7) != 0), c, rw, 6'($urandom & $urandom),
              w[71:0], 12'($urandom), 6'($urandom), 6'($urandom),
              ($urandom_range(0, 15) == 0));
    endtask

    // Monitor: compare every presented output against the oldest expectation.
    initial begin
        exp_t me;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                me = sb_q.pop_front();
                chk("red",        32'(bus.red),           32'(me.r));
                chk("green",      32'(bus.green),         32'(me.g));
                chk("blue",       32'(bus.blue),          32'(me.b));
                chk("hit",        32'(bus.hit),           32'(me.hit));
                chk("hit_pulse",  32'(bus.hit_pulse),     32'(me.pulse));
                chk("hit_col",    32'(bus.hit_col),       32'(me.col));
                chk("hit_row",    32'(bus.hit_row),       32'(me.row));
                chk("hit_layers", 32'(bus.hit_layers),    32'(me.hl));
                chk("scroll",     32'(bus.scroll_offset), 32'(me.scroll));
            end
        end
    end

    initial begin
        logic [71:0] lrgb;
        lrgb = {12'h666, 12'h555, 12'h444, 12'h333, 12'h222, 12'h111};
        rst = 1'b1;
        bus.visible = 0; bus.display_col = 0; bus.display_row = 0;
        bus.layer_visible = 0; bus.layer_rgb = 0; bus.bg_rgb = 0;
        bus.player_mask = 0; bus.hazard_mask = 0; bus.hit_clear = 0;
        m_hit = 0; m_col = 0; m_row = 0; m_hl = 0; m_scroll = 0;

        // start-up reset, some random traffic, then a mid-frame reset
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (20) rand_apply(0);
        apply(1, 1, 300, 400, 6'b000001, lrgb, 12'hABC, 6'b000001, 6'b000010, 0);
        apply(1, 1, 301, 400, 6'b000001, lrgb, 12'hABC, 6'b000001, 6'b000010, 0);

        // priority mux and background fallback
        apply(0, 1, 100, 100, 6'b001010, lrgb, 12'h123, 0, 0, 0);
        apply(0, 1, 101, 100, 6'b000000, lrgb, 12'h123, 0, 0, 0);
        apply(0, 0, 102, 100, 6'b000001, lrgb, 12'h123, 0, 0, 0);
        // layer in both masks alone: no self-collision
        apply(0, 1, 103, 100, 6'b000001, lrgb, 12'h123, 6'b000001, 6'b000001, 0);

        // first hit captures coordinates, later hit does not
        apply(0, 1, 640, 500, 6'b000101, lrgb, 12'h123, 6'b000001, 6'b001110, 0);
        apply(0, 1, 641, 500, 6'b000000, lrgb, 12'h123, 6'b000001, 6'b001110, 0);
        apply(0, 1, 700, 510, 6'b000101, lrgb, 12'h123, 6'b000001, 6'b001110, 0);

        // clear and collision together: collision wins
        apply(0, 1, 10, 20, 6'b000101, lrgb, 12'h123, 6'b000001, 6'b001110, 1);
        apply(0, 1, 11, 20, 6'b000000, lrgb, 12'h123, 6'b000001, 6'b001110, 0);

        // clear, then frame starts until the scroll wraps (4094 -> 1)
        apply(0, 1, 1, 1, 6'b000000, lrgb, 12'h123, 6'b000001, 6'b001110, 1);
        repeat (2731) apply(0, 0, 0, 0, 6'b000000, lrgb, 12'h123, 6'b000001, 6'b001110, 0);
        apply(0, 1, 50, 60, 6'b000101, lrgb, 12'h123, 6'b000001, 6'b001110, 0);
        repeat (2) apply(0, 0, 0, 0, 6'b000000, lrgb, 12'h123, 6'b000001, 6'b001110, 0);

        // per-layer hazard flags
        apply(0, 1, 2, 2, 6'b000000, lrgb, 12'h123, 6'b000001, 6'b001110, 1);
        apply(0, 1, 5, 5, 6'b001101, lrgb, 12'h123, 6'b000001, 6'b001110, 0);
        apply(0, 1, 6, 5, 6'b000000, lrgb, 12'h123, 6'b000001, 6'b001110, 0);

        // randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++) rand_apply($urandom_range(0, 199) == 0);

        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d pending required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
